timer_bank: RTL
===============

Name: timer_bank

Overview:
Parametrised multi-channel programmable timer, successor to the fixed three-channel counter peripheral on the IO bus.
- All channels run in the single system clock domain; per-channel count-enable strobes replace the separate counter clocks.
- Adds selectable count modes, per-channel enable, sticky interrupt flags and a registered readback port.
- Sits behind the IO bus decoder, which drives the write/select/data inputs. Outputs go to the interrupt logic and external pins.

Parameters:
CH_NUM, 3, number of timer channels (1..4)
WIDTH, 32, counter/reload width in bits
CH_BITS, 2, width of channel select; must satisfy 2^CH_BITS >= CH_NUM

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cnt_tick  in  CH_NUM  per-channel count strobe, one clk wide, already synchronised upstream
counter_we  in  1  write strobe from bus decoder
counter_ch  in  CH_BITS  channel select for write and readback
counter_reg  in  1  0 = write reload register, 1 = write control register
counter_val  in  WIDTH  write data
counter_out  out  WIDTH  registered count of selected channel
counter_OUT  out  CH_NUM  per-channel timer output
counter_irq  out  CH_NUM  sticky terminal-event flags

Behaviour:
- Reset (rst=1 at clk edge):
  - count, reload, ctrl, counter_OUT, counter_irq and counter_out all go to 0.
  - Reset mid-count aborts immediately.
- Control word, counter_val[3:0]:
  - [1:0] mode: 0 one-shot, 1 rate generator, 2 square wave, 3 free-run up-count.
  - [2] enable.
  - [3] irq clear, write-1.
  - Upper bits ignored.
- Reload write: reload <= val and count <= val on the same edge; OUT goes to the mode's initial level.
- Control write: ctrl updated; count <= reload; OUT goes to the new mode's initial level.
- Initial OUT level per mode: mode0 = 0, mode1 = 1, mode2 = 1, mode3 = 0.
- Writes with counter_ch >= CH_NUM are ignored.
- Counting occurs only when enable=1 and cnt_tick[i]=1 at the clk edge. Enable=0 freezes count and OUT.
- Mode0, one-shot:
  - Each tick decrements count.
  - On the tick with count==1 (or count==0): count = 0, OUT <= 1, irq set.
  - Then stays at 0 with OUT high; further ticks have no effect until a reload or control write.
- Mode1, rate generator:
  - Each tick decrements count.
  - On the tick with count==1: count <= reload, OUT <= 0 for exactly one clk then back to 1, irq set.
  - Reload < 2: channel holds, OUT stays 1, no irq.
- Mode2, square wave:
  - Each tick decrements count.
  - On the tick with count==1: OUT toggles, count <= reload, irq set on the falling toggle only.
  - Period is 2*reload ticks. Reload 0 holds.
- Mode3, free-run:
  - Each tick increments count.
  - On the wrap 2^WIDTH-1 -> 0: OUT pulses high for one clk and irq is set.
  - Reload sets the start value.
- Simultaneous write and tick on the same channel: write wins, tick is discarded. Other channels are unaffected.
- irq set and irq clear in the same cycle: set wins.
- Readback:
  - counter_out <= count[counter_ch] every clk, giving 1-cycle latency. It reflects the count before that edge's update.
  - counter_ch >= CH_NUM reads 0.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - counter_val narrower than the control field uses only bits [3:0].

Test Plan:
- Reset: drive rst=1 for 2 clk mid-count in mode1 -> next cycle all counts, counter_OUT, counter_irq and counter_out are 0.
- Mode0: ch0 reload=0x10, ctrl=0x4, then 16 ticks -> counter_OUT[0] rises on the 16th tick edge and irq[0]=1. A 17th tick leaves count=0 and OUT=1. Writing ctrl=0xC clears irq[0].
- Mode1: ch1 reload=5, ctrl=0x5, continuous ticks -> OUT[1] low for one clk every 5 ticks and irq[1] set. Reload=1 -> OUT[1] stays 1 and no irq.
- Mode2: ch2 reload=3, ctrl=0x6, tick every clk -> OUT[2] toggles every 3 clk (period 6). Readback with counter_ch=2 lags the internal count by 1 clk.
- Mode3 wrap: WIDTH=8 instance, reload=0xFE, ctrl=0x7, 2 ticks -> count reads 0, OUT pulses one clk, irq set. Enable=0 then further ticks -> count frozen.
- Collisions: reload write and tick on ch0 in the same clk -> count equals the written value. irq set and clear in the same clk -> irq stays 1. Write with counter_ch=3 while CH_NUM=3 -> no state change and readback 0.

Source files
------------

// File: rtl/timer_bank.sv
// timer_bank: parametrised multi-channel programmable timer.
//
// Each channel has a reload register, a control word (mode, enable),
// a down/up counter, a timer output pin and a sticky interrupt flag.
// All channels share one clock; counting is gated by per-channel
// one-cycle strobes on cnt_tick.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   cnt_tick     per-channel count strobe (one clk wide)
//   counter_we   write strobe from the bus decoder
//   counter_ch   channel select for write and readback
//   counter_reg  0 = write reload register, 1 = write control register
//   counter_val  write data (control word uses bits [3:0])
//   counter_out  registered count of the selected channel (1-cycle latency)
//   counter_OUT  per-channel timer output
//   counter_irq  per-channel sticky terminal-event flags
//
// Control word: [1:0] mode (0 one-shot, 1 rate, 2 square, 3 free-run),
//               [2] enable, [3] irq clear (write-1).
module timer_bank #(
  parameter int unsigned CH_NUM  = 3,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CH_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH_NUM-1:0]  cnt_tick,
  input  logic               counter_we,
  input  logic [CH_BITS-1:0] counter_ch,
  input  logic               counter_reg,
  input  logic [WIDTH-1:0]   counter_val,
  output logic [WIDTH-1:0]   counter_out,
  output logic [CH_NUM-1:0]  counter_OUT,
  output logic [CH_NUM-1:0]  counter_irq
);

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RATE    = 2'd1,
    MODE_SQUARE  = 2'd2,
    MODE_FREERUN = 2'd3
  } mode_e;

  // Output level a channel takes right after a reload or control write.
  function automatic logic init_level(input mode_e m);
    return (m == MODE_RATE) || (m == MODE_SQUARE);
  endfunction

  logic [WIDTH-1:0]  count_q  [CH_NUM];
  logic [WIDTH-1:0]  count_d  [CH_NUM];
  logic [WIDTH-1:0]  reload_q [CH_NUM];
  logic [WIDTH-1:0]  reload_d [CH_NUM];
  mode_e             mode_q   [CH_NUM];
  mode_e             mode_d   [CH_NUM];
  logic [CH_NUM-1:0] en_q,    en_d;
  logic [CH_NUM-1:0] out_q,   out_d;
  logic [CH_NUM-1:0] irq_q,   irq_d;
  // One-shot has fired and ignores ticks until re-armed by a write.
  logic [CH_NUM-1:0] armed_q, armed_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic [CH_NUM-1:0] wr_hit;
  logic [CH_NUM-1:0] adv;
  logic [CH_NUM-1:0] irq_set;
  logic [CH_NUM-1:0] irq_clr;
  logic [3:0]        ctrl_w;
  logic              sel_ok;

  always_comb begin
    ctrl_w  = 4'(counter_val);
    sel_ok  = (32'(counter_ch) < CH_NUM);
    wr_hit  = '0;
    adv     = '0;
    irq_set = '0;
    irq_clr = '0;
    en_d    = en_q;
    out_d   = out_q;
    armed_d = armed_q;
    irq_d   = irq_q;

    for (int unsigned i = 0; i < CH_NUM; i++) begin
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      mode_d[i]   = mode_q[i];

      wr_hit[i] = counter_we && sel_ok && (counter_ch == CH_BITS'(i));
      adv[i]    = cnt_tick[i] && en_q[i];

      unique case (mode_q[i])
        MODE_ONESHOT: begin
          if (adv[i] && armed_q[i]) begin
            if ((count_q[i] == '0) || (count_q[i] == WIDTH'(1))) begin
              count_d[i]  = '0;
              out_d[i]    = 1'b1;
              irq_set[i]  = 1'b1;
              armed_d[i]  = 1'b0;
            end else begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end
          end
        end
        MODE_RATE: begin
          // Output idles high; the terminal tick drops it for one clk only.
          out_d[i] = 1'b1;
          if (adv[i] && (reload_q[i] > WIDTH'(1))) begin
            if (count_q[i] == WIDTH'(1)) begin
              count_d[i] = reload_q[i];
              out_d[i]   = 1'b0;
              irq_set[i] = 1'b1;
            end else begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end
          end
        end
        MODE_SQUARE: begin
          if (adv[i] && (reload_q[i] != '0)) begin
            if (count_q[i] == WIDTH'(1)) begin
              count_d[i] = reload_q[i];
              out_d[i]   = ~out_q[i];
              irq_set[i] = out_q[i];
            end else begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end
          end
        end
        MODE_FREERUN: begin
          // Output idles low; the wrap raises it for one clk only.
          out_d[i] = 1'b0;
          if (adv[i]) begin
            count_d[i] = count_q[i] + WIDTH'(1);
            if (count_q[i] == '1) begin
              out_d[i]   = 1'b1;
              irq_set[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A bus write overrides the tick's effect on count/OUT/arming, but a
      // terminal event in the same clk still latches the irq flag so that a
      // simultaneous write-1-to-clear cannot lose it.
      if (wr_hit[i]) begin
        armed_d[i] = 1'b1;
        if (counter_reg) begin
          mode_d[i]   = mode_e'(ctrl_w[1:0]);
          en_d[i]     = ctrl_w[2];
          irq_clr[i]  = ctrl_w[3];
          count_d[i]  = reload_q[i];
          out_d[i]    = init_level(mode_e'(ctrl_w[1:0]));
        end else begin
          reload_d[i] = counter_val;
          count_d[i]  = counter_val;
          out_d[i]    = init_level(mode_q[i]);
        end
      end

      irq_d[i] = irq_set[i] | (irq_q[i] & ~irq_clr[i]);
    end
  end

  // Readback samples the count before this edge's update.
  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (counter_ch == CH_BITS'(i)) begin
        rdata_d = count_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        mode_q[i]   <= MODE_ONESHOT;
      end
      en_q    <= '0;
      out_q   <= '0;
      irq_q   <= '0;
      armed_q <= '0;
      rdata_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        mode_q[i]   <= mode_d[i];
      end
      en_q    <= en_d;
      out_q   <= out_d;
      irq_q   <= irq_d;
      armed_q <= armed_d;
      rdata_q <= rdata_d;
    end
  end

  assign counter_out = rdata_q;
  assign counter_OUT = out_q;
  assign counter_irq = irq_q;

endmodule
